// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, waits a fixed latency,
// then commits the access to a word-addressed array and returns the response.
module mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int NB     = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit ZERO_LAT = (LATENCY == 0);
    localparam logic [ADDR_W-1:0] NB_A    = ADDR_W'(NB);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                started;
    logic [3:0]          cnt;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_wstrb;

    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                enter_resp;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [NB-1:0]       acc_wstrb;
    logic [ADDR_W-1:0]   acc_word;
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_err;

    // State register; started keeps req_ready low until the first edge after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
        end
    end

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = ZERO_LAT ? S_RESP : S_WAIT;
            S_WAIT: if (cnt <= 4'd1) state_nx = S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE) && started;
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_nx == S_RESP) && (state != S_RESP);

    // With zero latency the commit edge is the accept edge, so use the live request.
    assign acc_we    = ZERO_LAT ? req_we    : lat_we;
    assign acc_addr  = ZERO_LAT ? req_addr  : lat_addr;
    assign acc_wdata = ZERO_LAT ? req_wdata : lat_wdata;
    assign acc_wstrb = ZERO_LAT ? req_wstrb : lat_wstrb;
    assign acc_word  = acc_addr / NB_A;
    assign acc_idx   = acc_word[IDX_W-1:0];
    assign acc_err   = ((acc_addr % NB_A) != '0) || (acc_word >= DEPTH_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= 4'(LATENCY);
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? '0 : mem[acc_idx];
            end else if (rsp_valid && rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // NOTE: the storage array has no reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule
